// File: rtl/jstk_dir_stepper.sv
// Joystick direction decoder and cursor stepper: per-axis hysteresis zones, debounced commit,
// bound-gated direction mode and saturating X/Y positions with single-step and auto-repeat.
module jstk_dir_stepper #(
   parameter int unsigned DATA_W   = 10,
   parameter int unsigned HI_TH    = 700,
   parameter int unsigned LO_TH    = 300,
   parameter int unsigned HYST     = 20,
   parameter int unsigned STABLE_N = 3,
   parameter int unsigned POS_W    = 4,
   parameter int unsigned POS_MIN  = 2,
   parameter int unsigned POS_MAX  = 6,
   parameter int unsigned POS_INIT = 4,
   parameter int unsigned REPEAT_N = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              sample_vld,
   input  logic [DATA_W-1:0] x_in,
   input  logic [DATA_W-1:0] y_in,
   output logic [3:0]        mode,
   output logic              mode_vld,
   output logic              step,
   output logic [POS_W-1:0]  x_pos,
   output logic [POS_W-1:0]  y_pos
);

   localparam int unsigned SW = $clog2(STABLE_N + 1);
   localparam int unsigned RW = (REPEAT_N == 0) ? 1 : $clog2(REPEAT_N + 1);

   localparam logic [DATA_W-1:0] HI_V     = DATA_W'(HI_TH);
   localparam logic [DATA_W-1:0] LO_V     = DATA_W'(LO_TH);
   localparam logic [DATA_W-1:0] HI_OUT   = DATA_W'(HI_TH - HYST);
   localparam logic [DATA_W-1:0] LO_OUT   = DATA_W'(LO_TH + HYST);
   localparam logic [SW-1:0]     STABLE_V = SW'(STABLE_N);
   localparam logic [RW-1:0]     RPT_V    = RW'(REPEAT_N);
   localparam logic [POS_W-1:0]  PMIN     = POS_W'(POS_MIN);
   localparam logic [POS_W-1:0]  PMAX     = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0]  PINIT    = POS_W'(POS_INIT);

   typedef enum logic [1:0] {ZMid, ZLow, ZHigh} zone_e;

   function automatic zone_e next_zone(input zone_e z, input logic [DATA_W-1:0] v);
      zone_e n;
      n = z;
      case (z)
         ZMid:    if (v > HI_V) n = ZHigh; else if (v < LO_V) n = ZLow;
         ZHigh:   if (v < LO_V) n = ZLow;  else if (v <= HI_OUT) n = ZMid;
         ZLow:    if (v > HI_V) n = ZHigh; else if (v >= LO_OUT) n = ZMid;
         default: n = ZMid;
      endcase
      return n;
   endfunction

   // Internal direction vector is {left, right, up, down}; map it onto the output code.
   function automatic logic [3:0] encode(input logic [3:0] d);
      logic [3:0] m;
      case (d)
         4'b1000: m = 4'b0001;
         4'b0010: m = 4'b0010;
         4'b0100: m = 4'b0100;
         4'b0001: m = 4'b1000;
         4'b1010: m = 4'b0011;
         4'b1001: m = 4'b0101;
         4'b0110: m = 4'b0110;
         4'b0101: m = 4'b0111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   zone_e            x_zone_q, y_zone_q, x_zone_d, y_zone_d;
   logic [3:0]       cand, prev_q, commit_q, commit_d, gated;
   logic [SW-1:0]    stable_q, stable_d;
   logic [RW-1:0]    rpt_q, rpt_d, rpt_inc;
   logic             changed, trigger, step_d;
   logic [POS_W-1:0] x_pos_d, y_pos_d;

   always_comb begin
      x_zone_d = next_zone(x_zone_q, x_in);
      y_zone_d = next_zone(y_zone_q, y_in);
      cand = {x_zone_d == ZHigh, x_zone_d == ZLow, y_zone_d == ZHigh, y_zone_d == ZLow};

      if (cand == prev_q) stable_d = (stable_q == STABLE_V) ? stable_q : stable_q + SW'(1);
      else                stable_d = SW'(1);
      commit_d = (stable_d == STABLE_V) ? cand : commit_q;

      // Gating looks at the positions as they stand before this sample moves them.
      gated = {commit_d[3] && (x_pos > PMIN), commit_d[2] && (x_pos < PMAX),
               commit_d[1] && (y_pos < PMAX), commit_d[0] && (y_pos > PMIN)};

      changed = (commit_d != commit_q);
      rpt_inc = rpt_q + RW'(1);
      trigger = (|commit_d) && (changed || ((REPEAT_N != 0) && (rpt_inc == RPT_V)));
      rpt_d   = (changed || trigger || !(|commit_d) || (REPEAT_N == 0)) ? '0 : rpt_inc;
      step_d  = trigger && (|gated);

      x_pos_d = x_pos;
      y_pos_d = y_pos;
      if (step_d) begin
         if (gated[3])      x_pos_d = x_pos - POS_W'(1);
         else if (gated[2]) x_pos_d = x_pos + POS_W'(1);
         if (gated[1])      y_pos_d = y_pos + POS_W'(1);
         else if (gated[0]) y_pos_d = y_pos - POS_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         x_zone_q <= ZMid;
         y_zone_q <= ZMid;
         prev_q   <= '0;
         commit_q <= '0;
         stable_q <= '0;
         rpt_q    <= '0;
         mode     <= '0;
         mode_vld <= 1'b0;
         step     <= 1'b0;
         x_pos    <= PINIT;
         y_pos    <= PINIT;
      end else begin
         mode_vld <= sample_vld;
         step     <= sample_vld & step_d;
         if (sample_vld) begin
            x_zone_q <= x_zone_d;
            y_zone_q <= y_zone_d;
            prev_q   <= cand;
            commit_q <= commit_d;
            stable_q <= stable_d;
            rpt_q    <= rpt_d;
            mode     <= encode(gated);
            x_pos    <= x_pos_d;
            y_pos    <= y_pos_d;
         end
      end
   end

endmodule
